// File: rtl/mp3_pkg.sv
// Shared types and constants for the flash byte sequencer: FSM states,
// byte-lane indices and the flash word-address width.
package mp3_pkg;

    localparam int WORD_ADDR_W = 23;

    typedef logic [1:0] byte_idx_t;

    localparam byte_idx_t FIRST  = 2'd0;
    localparam byte_idx_t SECOND = 2'd1;
    localparam byte_idx_t THIRD  = 2'd2;
    localparam byte_idx_t FOURTH = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        EMIT,
        FINISH
    } seq_state_t;

endpackage

// File: rtl/address_select.sv
// Next-position calculator: steps the byte lane within a 32-bit word and
// moves the word address by WORD_DELTA when the lane wraps.
module address_select
    import mp3_pkg::*;
#(
    parameter int WORD_DELTA = 1
) (
    input  logic [WORD_ADDR_W-1:0] word,
    input  logic [1:0]             byte_idx,
    input  logic                   reverse,
    output logic [WORD_ADDR_W-1:0] next_word,
    output logic [1:0]             next_byte,
    output logic                   word_change
);

    localparam logic [WORD_ADDR_W-1:0] DELTA = WORD_ADDR_W'(WORD_DELTA);

    // NOTE: every output gets a default first so no path through the block leaves one unassigned (no latch).
    always_comb begin
        next_word = word;
        next_byte = byte_idx;
        if (reverse) begin
            if (byte_idx == FIRST) begin
                next_word = word - DELTA;
                next_byte = FOURTH;
            end else begin
                next_byte = byte_idx - 2'd1;
            end
        end else begin
            if (byte_idx == FOURTH) begin
                next_word = word + DELTA;
                next_byte = FIRST;
            end else begin
                next_byte = byte_idx + 2'd1;
            end
        end
    end

    // Compared rather than inferred from the lane wrap so WORD_DELTA=0 stays in the word.
    assign word_change = (next_word != word);

endmodule

// File: rtl/flash_byte_sequencer.sv
// Streams the bytes of a flash word region forward or backward, one 32-bit read per word.
// Optional macro FLASH_SEQ_LOOP_EN: wrap to the region start instead of finishing.
module flash_byte_sequencer
    import mp3_pkg::*;
#(
    parameter int WORD_DELTA = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   pause,
    input  logic                   reverse,
    input  logic [WORD_ADDR_W-1:0] start_word,
    input  logic [WORD_ADDR_W-1:0] end_word,
    output logic                   flash_read,
    output logic [WORD_ADDR_W-1:0] flash_address,
    input  logic                   flash_waitrequest,
    input  logic [31:0]            flash_readdata,
    input  logic                   flash_readdatavalid,
    output logic [7:0]             byte_out,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic                   busy,
    output logic                   done
);

    seq_state_t state, next_state;

    logic [WORD_ADDR_W-1:0] lo_word, hi_word, word, next_word;
    logic [1:0]             byte_idx, next_byte;
    logic [31:0]            buffer;
    logic                   word_change, bounds_ok, accept, at_end;

    assign bounds_ok = (start_word <= end_word);
    assign accept    = (state == EMIT) && !pause && byte_ready;
    assign at_end    = reverse ? (word == lo_word && byte_idx == FIRST)
                               : (word == hi_word && byte_idx == FOURTH);

    address_select #(
        .WORD_DELTA (WORD_DELTA)
    ) u_address_select (
        .word        (word),
        .byte_idx    (byte_idx),
        .reverse     (reverse),
        .next_word   (next_word),
        .next_byte   (next_byte),
        .word_change (word_change)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (start) next_state = bounds_ok ? REQ : FINISH;
            REQ:       if (!pause && !flash_waitrequest) next_state = WAIT_DATA;
            WAIT_DATA: if (flash_readdatavalid) next_state = EMIT;
            EMIT: begin
                if (accept) begin
                    if (at_end) begin
`ifdef FLASH_SEQ_LOOP_EN
                        next_state = REQ;
`else
                        next_state = FINISH;
`endif
                    end else if (word_change) begin
                        next_state = REQ;
                    end
                end
            end
            FINISH:    next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        flash_read = 1'b0;
        byte_valid = 1'b0;
        busy       = (state != IDLE);
        done       = (state == FINISH);
        case (state)
            REQ:     flash_read = !pause;
            EMIT:    byte_valid = !pause;
            default: ;
        endcase
    end

    assign flash_address = word;
    assign byte_out      = buffer[{byte_idx, 3'b000} +: 8];

    // NOTE: the word buffer is a plain 32-bit register, so clearing it on reset is cheap and keeps byte_out at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_word  <= '0;
            hi_word  <= '0;
            word     <= '0;
            byte_idx <= FIRST;
            buffer   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && bounds_ok) begin
                        lo_word  <= start_word;
                        hi_word  <= end_word;
                        word     <= reverse ? end_word : start_word;
                        byte_idx <= reverse ? FOURTH : FIRST;
                    end
                end
                WAIT_DATA: if (flash_readdatavalid) buffer <= flash_readdata;
                EMIT: begin
                    if (accept) begin
                        if (!at_end) begin
                            word     <= next_word;
                            byte_idx <= next_byte;
                        end
`ifdef FLASH_SEQ_LOOP_EN
                        else begin
                            word     <= reverse ? hi_word : lo_word;
                            byte_idx <= reverse ? FOURTH : FIRST;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
